// File: rtl/online_adder_stream.sv
// Radix-2 signed-digit online adder, MSD first, online delay 2.
// Per-channel one-digit holding registers, per-frame add/sub, automatic 2-step flush.
module online_adder_stream #(
  parameter int NDIGITS = 8,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic asyn_reset,
  input  logic x_plus,
  input  logic x_minus,
  input  logic data_x_vld,
  output logic data_x_rdy,
  input  logic y_plus,
  input  logic y_minus,
  input  logic data_y_vld,
  output logic data_y_rdy,
  input  logic sub,
  output logic z_plus,
  output logic z_minus,
  output logic data_out_vld,
  input  logic data_out_rdy,
  output logic data_out_last
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] IN_LIMIT  = CNT_W'(NDIGITS);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] STEP_END  = CNT_W'(NDIGITS + 1);

  state_t             state, state_nxt;
  logic               started;
  logic               hx_full, hy_full;
  logic signed [1:0]  hx_dig, hy_dig;
  logic [CNT_W-1:0]   x_cnt, y_cnt, step_cnt;
  logic               sub_q;
  logic signed [2:0]  res, res_nxt;
  logic               step, acc_x, acc_y, sub_eff;
  logic signed [1:0]  x_in, y_in;
  logic signed [2:0]  v_sum;
  logic signed [3:0]  t_val, t_adj;
  logic               zp_nxt, zm_nxt;

  function automatic logic signed [1:0] sd_decode(input logic p, input logic m);
    case ({p, m})
      2'b10:   return 2'sb01;
      2'b01:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  // Subtraction swaps the Y digit polarity; digit 1 uses the live sub input.
  assign sub_eff = (y_cnt == '0) ? sub : sub_q;
  assign x_in    = sd_decode(x_plus, x_minus);
  assign y_in    = sub_eff ? sd_decode(y_minus, y_plus) : sd_decode(y_plus, y_minus);

  assign step = started
              && ((state == FLUSH) || (hx_full && hy_full))
              && (!data_out_vld || data_out_rdy);

  assign data_x_rdy = started && (state == RUN) && (!hx_full || step) && (x_cnt < IN_LIMIT);
  assign data_y_rdy = started && (state == RUN) && (!hy_full || step) && (y_cnt < IN_LIMIT);
  assign acc_x      = data_x_vld && data_x_rdy;
  assign acc_y      = data_y_vld && data_y_rdy;

  // Residual r in [-2,2] holds 4*(partial input sum - emitted sum) at the current scale;
  // t = 2r + v, select z so that t - 4z stays in [-2,2]. Two zero steps drive r to 0.
  always_comb begin
    v_sum  = '0;
    zp_nxt = 1'b0;
    zm_nxt = 1'b0;
    if (state == RUN)
      v_sum = {hx_dig[1], hx_dig} + {hy_dig[1], hy_dig};
    t_val = $signed({res, 1'b0}) + $signed({v_sum[2], v_sum});
    t_adj = t_val;
    if (t_val >= 4'sd3) begin
      zp_nxt = 1'b1;
      t_adj  = t_val - 4'sd4;
    end else if (t_val <= -4'sd3) begin
      zm_nxt = 1'b1;
      t_adj  = t_val + 4'sd4;
    end
    res_nxt = t_adj[2:0];
  end

  always_comb begin
    state_nxt = state;
    if (step) begin
      if (state == RUN && step_cnt == STEP_LAST)
        state_nxt = FLUSH;
      else if (state == FLUSH && step_cnt == STEP_END)
        state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      started  <= 1'b0;
      hx_full  <= 1'b0;
      hy_full  <= 1'b0;
      hx_dig   <= '0;
      hy_dig   <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      step_cnt <= '0;
      sub_q    <= 1'b0;
      res      <= '0;
    end else begin
      started <= 1'b1;
      if (acc_x) begin
        hx_full <= 1'b1;
        hx_dig  <= x_in;
        x_cnt   <= x_cnt + 1'b1;
      end else if (step && state == RUN) begin
        hx_full <= 1'b0;
      end
      if (acc_y) begin
        hy_full <= 1'b1;
        hy_dig  <= y_in;
        y_cnt   <= y_cnt + 1'b1;
        if (y_cnt == '0)
          sub_q <= sub;
      end else if (step && state == RUN) begin
        hy_full <= 1'b0;
      end
      if (step) begin
        if (state == FLUSH && step_cnt == STEP_END) begin
          res      <= '0;
          step_cnt <= '0;
          x_cnt    <= '0;
          y_cnt    <= '0;
        end else begin
          res      <= res_nxt;
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      data_out_vld  <= 1'b0;
      z_plus        <= 1'b0;
      z_minus       <= 1'b0;
      data_out_last <= 1'b0;
    end else if (step && step_cnt != '0) begin
      data_out_vld  <= 1'b1;
      z_plus        <= zp_nxt;
      z_minus       <= zm_nxt;
      data_out_last <= (step_cnt == STEP_END);
    end else if (data_out_rdy) begin
      data_out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_online_adder_stream.sv
// Self-checking bench for online_adder_stream: frame values checked against exact
// scaled-integer arithmetic of the operand digits.
module tb_online_adder_stream;
  localparam int N = 4;

  logic clk = 1'b0;
  logic asyn_reset = 1'b1;
  logic x_plus = 1'b0, x_minus = 1'b0, data_x_vld = 1'b0, data_x_rdy;
  logic y_plus = 1'b0, y_minus = 1'b0, data_y_vld = 1'b0, data_y_rdy;
  logic sub = 1'b0;
  logic z_plus, z_minus, data_out_vld, data_out_last;
  logic data_out_rdy = 1'b1;

  int  checks = 0, errors = 0;
  int  rdy_mode = 0;
  bit  abort_drive = 1'b0;
  int  cyc_ctr = 0;
  int  xs[64], ys[64];
  bit  subs[16];
  int  zq[$];
  bit  zl[$];
  int  zc[$];

  online_adder_stream #(.NDIGITS(N), .CNT_W(8)) dut (
    .clk(clk), .asyn_reset(asyn_reset),
    .x_plus(x_plus), .x_minus(x_minus), .data_x_vld(data_x_vld), .data_x_rdy(data_x_rdy),
    .y_plus(y_plus), .y_minus(y_minus), .data_y_vld(data_y_vld), .data_y_rdy(data_y_rdy),
    .sub(sub), .z_plus(z_plus), .z_minus(z_minus), .data_out_vld(data_out_vld),
    .data_out_rdy(data_out_rdy), .data_out_last(data_out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr++;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       data_out_rdy = 1'b1;
      1:       data_out_rdy = 1'($urandom_range(0, 1));
      default: data_out_rdy = 1'b0;
    endcase
  end

  // Capture every digit that the next rising edge transfers.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!asyn_reset && data_out_vld && data_out_rdy) begin
        checks++;
        if (z_plus && z_minus) begin
          errors++;
          $display("FAIL canonical: z=11 got, required 10/01/00");
        end
        zq.push_back(z_plus ? 1 : (z_minus ? -1 : 0));
        zl.push_back(data_out_last);
        zc.push_back(cyc_ctr);
      end
    end
  end

  // Digit codes: 1, -1, 0, and 2 meaning the redundant-zero pattern 11.
  function automatic logic [1:0] enc(input int d);
    case (d)
      1:       return 2'b10;
      -1:      return 2'b01;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int dval(input int d);
    return (d == 2) ? 0 : d;
  endfunction

  function automatic int rand_digit();
    int r = int'($urandom_range(0, 3));
    return (r == 3) ? 2 : r - 1;
  endfunction

  function automatic int exp_val(input int f);
    int acc = 0;
    for (int i = 0; i < N; i++) begin
      if (subs[f]) acc += (dval(xs[f*N+i]) - dval(ys[f*N+i])) * (1 << (N-1-i));
      else         acc += (dval(xs[f*N+i]) + dval(ys[f*N+i])) * (1 << (N-1-i));
    end
    return acc;
  endfunction

  function automatic int got_val(input int f);
    int acc = 0;
    for (int j = 0; j <= N; j++)
      if (f*(N+1)+j < zq.size()) acc += zq[f*(N+1)+j] * (1 << (N-j));
    return acc;
  endfunction

  function automatic int last_errs(input int f);
    int e = 0;
    for (int j = 0; j <= N; j++)
      if (f*(N+1)+j < zl.size() && zl[f*(N+1)+j] != (j == N)) e++;
    return e;
  endfunction

  task automatic load_frame(input int f, input int xd[4], input int yd[4], input bit s);
    for (int i = 0; i < N; i++) begin
      xs[f*N+i] = xd[i];
      ys[f*N+i] = yd[i];
    end
    subs[f] = s;
  endtask

  task automatic clear_out();
    zq.delete();
    zl.delete();
    zc.delete();
  endtask

  task automatic drive_stream(input int nfr, input int xdel, input int ydel, output int x_pre_y);
    int xi = 0, yi = 0, cyc = 0;
    int tot = nfr * N;
    x_pre_y = 0;
    while ((xi < tot || yi < tot) && !abort_drive && cyc < 3000) begin
      @(negedge clk);
      data_x_vld = (xi < tot) && (cyc >= xdel);
      {x_plus, x_minus} = data_x_vld ? enc(xs[xi]) : 2'b00;
      data_y_vld = (yi < tot) && (cyc >= ydel);
      {y_plus, y_minus} = data_y_vld ? enc(ys[yi]) : 2'b00;
      sub = (yi < tot) ? subs[yi / N] : 1'b0;
      #1;
      if (data_x_vld && data_x_rdy) xi++;
      if (data_y_vld && data_y_rdy) yi++;
      if (cyc < ydel) x_pre_y = xi;
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: accepted x=%0d y=%0d, required %0d each", xi, yi, tot);
    end
    @(posedge clk);
    #1;
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    while (zq.size() < n && w < 600) begin
      @(negedge clk);
      #3;
      w++;
    end
    repeat (10) @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_x_rdy, data_y_rdy, data_out_vld, z_plus, z_minus, data_out_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {data_x_rdy, data_y_rdy, data_out_vld, z_plus, z_minus, data_out_last});
    end
    @(negedge clk);
    asyn_reset = 1'b0;
    #1;
    checks++;
    if ({data_x_rdy, data_y_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL rdy_before_first_clk: got %b, required 00", {data_x_rdy, data_y_rdy});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({data_x_rdy, data_y_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL rdy_after_first_clk: got %b, required 11", {data_x_rdy, data_y_rdy});
    end
  endtask

  task automatic test_add_basic();
    int d;
    clear_out();
    load_frame(0, '{1, 1, 0, 0}, '{1, 0, 1, 0}, 1'b0);
    drive_stream(1, 0, 0, d);
    wait_out(5);
    checks++;
    if (zq.size() != 5) begin
      errors++;
      $display("FAIL add_count: got %0d digits, required 5", zq.size());
    end
    checks++;
    if (got_val(0) != exp_val(0)) begin
      errors++;
      $display("FAIL add_value: got %0d/16, required %0d/16", got_val(0), exp_val(0));
    end
    checks++;
    if (last_errs(0) != 0) begin
      errors++;
      $display("FAIL add_last: %0d misplaced last flags, required 0", last_errs(0));
    end
  endtask

  task automatic test_sub_then_neg();
    int d;
    clear_out();
    load_frame(0, '{1, 1, 0, 0}, '{1, 0, 1, 0}, 1'b1);
    load_frame(1, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, 1'b0);
    drive_stream(2, 0, 0, d);
    wait_out(10);
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (got_val(f) != exp_val(f)) begin
        errors++;
        $display("FAIL subneg_value[%0d]: got %0d/16, required %0d/16", f, got_val(f), exp_val(f));
      end
    end
    checks++;
    if (zq.size() != 10) begin
      errors++;
      $display("FAIL subneg_count: got %0d, required 10", zq.size());
    end
  endtask

  task automatic test_encoding();
    int d;
    clear_out();
    load_frame(0, '{1, 2, 1, 2}, '{0, 1, 0, 0}, 1'b0);
    load_frame(1, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0);
    drive_stream(2, 0, 0, d);
    wait_out(10);
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (got_val(f) != exp_val(f)) begin
        errors++;
        $display("FAIL encoding_value[%0d]: got %0d/16, required %0d/16", f, got_val(f), exp_val(f));
      end
    end
  endtask

  task automatic test_skew();
    int x_pre;
    clear_out();
    load_frame(0, '{1, 1, 0, 0}, '{1, 0, 1, 0}, 1'b0);
    drive_stream(1, 0, 3, x_pre);
    wait_out(5);
    checks++;
    if (x_pre != 1) begin
      errors++;
      $display("FAIL skew_x_buffered: got %0d X digits accepted before Y, required 1", x_pre);
    end
    checks++;
    if (zq.size() != 5 || got_val(0) != exp_val(0)) begin
      errors++;
      $display("FAIL skew_result: got %0d digits value %0d/16, required 5 digits value %0d/16",
               zq.size(), got_val(0), exp_val(0));
    end
  endtask

  task automatic test_backpressure();
    int d;
    logic [3:0] snap;
    clear_out();
    load_frame(0, '{1, -1, 1, 1}, '{0, 1, 1, -1}, 1'b0);
    fork
      drive_stream(1, 0, 0, d);
      begin
        int w = 0;
        while (zq.size() < 1 && w < 200) begin
          @(negedge clk);
          #3;
          w++;
        end
        rdy_mode = 2;
        @(negedge clk);
        #2;
        snap = {data_out_vld, z_plus, z_minus, data_out_last};
        checks++;
        if (snap[3] !== 1'b1) begin
          errors++;
          $display("FAIL stall_vld: got %b, required 1", snap[3]);
        end
        repeat (5) begin
          @(negedge clk);
          #2;
          checks++;
          if ({data_out_vld, z_plus, z_minus, data_out_last} !== snap) begin
            errors++;
            $display("FAIL stall_stable: got %b, required %b",
                     {data_out_vld, z_plus, z_minus, data_out_last}, snap);
          end
        end
        checks++;
        if ({data_x_rdy, data_y_rdy} !== 2'b00) begin
          errors++;
          $display("FAIL stall_rdy: got %b, required 00", {data_x_rdy, data_y_rdy});
        end
        rdy_mode = 0;
      end
    join
    wait_out(5);
    checks++;
    if (zq.size() != 5 || got_val(0) != exp_val(0) || last_errs(0) != 0) begin
      errors++;
      $display("FAIL stall_result: got %0d digits value %0d/16, required 5 digits value %0d/16",
               zq.size(), got_val(0), exp_val(0));
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_out();
    for (int f = 0; f < 2; f++)
      load_frame(f, '{rand_digit(), rand_digit(), rand_digit(), rand_digit()},
                 '{rand_digit(), rand_digit(), rand_digit(), rand_digit()}, 1'($urandom_range(0, 1)));
    drive_stream(2, 0, 0, d);
    wait_out(10);
    checks++;
    if (zq.size() != 10) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required 10", zq.size());
    end else begin
      checks++;
      if (zc[4] - zc[0] != 4) begin
        errors++;
        $display("FAIL b2b_full_rate: got span %0d, required 4", zc[4] - zc[0]);
      end
      checks++;
      if (zc[5] - zc[4] - 1 != 2) begin
        errors++;
        $display("FAIL b2b_bubbles: got %0d idle cycles, required 2", zc[5] - zc[4] - 1);
      end
    end
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (got_val(f) != exp_val(f) || last_errs(f) != 0) begin
        errors++;
        $display("FAIL b2b_value[%0d]: got %0d/16 (last errs %0d), required %0d/16",
                 f, got_val(f), last_errs(f), exp_val(f));
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    clear_out();
    load_frame(0, '{1, 1, 1, -1}, '{1, 0, 1, 1}, 1'b0);
    abort_drive = 1'b0;
    fork
      drive_stream(1, 0, 0, d);
      begin
        int w = 0;
        while (zq.size() < 2 && w < 200) begin
          @(negedge clk);
          #3;
          w++;
        end
        abort_drive = 1'b1;
        asyn_reset = 1'b1;
        #1;
        checks++;
        if ({data_x_rdy, data_y_rdy, data_out_vld, z_plus, z_minus, data_out_last} !== 6'b0) begin
          errors++;
          $display("FAIL midreset_outputs: got %b, required 000000",
                   {data_x_rdy, data_y_rdy, data_out_vld, z_plus, z_minus, data_out_last});
        end
      end
    join
    repeat (2) @(posedge clk);
    clear_out();
    abort_drive = 1'b0;
    @(negedge clk);
    asyn_reset = 1'b0;
    load_frame(0, '{-1, 1, 0, 1}, '{1, 1, -1, 0}, 1'b1);
    drive_stream(1, 0, 0, d);
    wait_out(5);
    checks++;
    if (zq.size() != 5 || got_val(0) != exp_val(0) || last_errs(0) != 0) begin
      errors++;
      $display("FAIL midreset_fresh: got %0d digits value %0d/16, required 5 digits value %0d/16",
               zq.size(), got_val(0), exp_val(0));
    end
  endtask

  task automatic test_random();
    int d;
    clear_out();
    for (int f = 0; f < 6; f++)
      load_frame(f, '{rand_digit(), rand_digit(), rand_digit(), rand_digit()},
                 '{rand_digit(), rand_digit(), rand_digit(), rand_digit()}, 1'($urandom_range(0, 1)));
    rdy_mode = 1;
    drive_stream(6, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
    wait_out(30);
    rdy_mode = 0;
    checks++;
    if (zq.size() != 30) begin
      errors++;
      $display("FAIL random_count: got %0d, required 30", zq.size());
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (got_val(f) != exp_val(f) || last_errs(f) != 0) begin
        errors++;
        $display("FAIL random_value[%0d]: got %0d/16 (last errs %0d), required %0d/16",
                 f, got_val(f), last_errs(f), exp_val(f));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_sub_then_neg();
    test_encoding();
    test_skew();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
